code_lock_controller: RTL and testbench

Sequencing controller for the four-digit BCD code comparator in the keypad lock design. Collects keypad digits into a four-digit shift register, presents them to the comparator, and strobes the comparator enable for one cycle once four digits are held. Then either opens the lock for a fixed time, or counts a failed attempt and enters a timed lockout after too many failures.

---
 rtl/code_lock_controller_if.sv | 43 ++++
 rtl/code_lock_controller.sv | 154 +++++++++++++++
 tb/tb_code_lock_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/code_lock_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_controller_if
// Purpose  : Bundles the keypad, comparator and lock-status signals of the
//            code lock controller.
// Signals  : digit_valid_i / digit_i  keypad digit strobe and BCD value
//            clear_i                  discard partial entry / relock early
//            equal_i                  comparator match result
//            bcd_0_o..bcd_3_o         held digits, bcd_0_o newest
//            cmp_enable_o             comparator enable pulse
//            digit_count_o            digits held (0..4)
//            unlock_o / error_o / alarm_o  lock status outputs
// Modports : master = keypad/comparator side, slave = controller
// Revision : 1.0  initial release
// ============================================================================
interface code_lock_controller_if;
  logic       digit_valid_i;
  logic [3:0] digit_i;
  logic       clear_i;
  logic       equal_i;
  logic [3:0] bcd_0_o;
  logic [3:0] bcd_1_o;
  logic [3:0] bcd_2_o;
  logic [3:0] bcd_3_o;
  logic       cmp_enable_o;
  logic [2:0] digit_count_o;
  logic       unlock_o;
  logic       error_o;
  logic       alarm_o;

  modport master (
    output digit_valid_i, digit_i, clear_i, equal_i,
    input  bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o, cmp_enable_o,
           digit_count_o, unlock_o, error_o, alarm_o
  );

  modport slave (
    input  digit_valid_i, digit_i, clear_i, equal_i,
    output bcd_0_o, bcd_1_o, bcd_2_o, bcd_3_o, cmp_enable_o,
           digit_count_o, unlock_o, error_o, alarm_o
  );
endinterface
`default_nettype wire

// File: rtl/code_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_controller
// Purpose  : Sequencer for a four-digit BCD keypad lock. Shifts keypad digits
//            into a four-digit register, strobes the comparator once four
//            digits are held, then opens the lock for a fixed time or counts
//            a failure and enters a timed lockout after too many failures.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - synchronous active-high reset
//            bus    - code_lock_controller_if.slave (keypad, comparator and
//                     status signals)
// Params   : MAX_ATTEMPTS   - consecutive failures that trigger lockout (1..15)
//            UNLOCK_CYCLES  - cycles unlock_o stays high after a match
//            LOCKOUT_CYCLES - cycles alarm_o stays high during lockout
// Revision : 1.0  initial release
// ============================================================================
module code_lock_controller #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 50000000,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  code_lock_controller_if.slave  bus
);

  localparam int C_TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW          = $clog2(C_TIMER_MAX) + 1;

  localparam logic [TW-1:0] c_unlock_load  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] c_lockout_load = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    c_max_attempts = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  state_e        state_q;
  logic [3:0]    bcd_q [4];
  logic [2:0]    count_q;
  logic          unlock_q;
  logic          error_q;
  logic          alarm_q;
  logic [3:0]    attempts_q;
  logic [TW-1:0] timer_q;

  logic [3:0]    attempts_inc_d;

  assign attempts_inc_d = attempts_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ENTRY;
      bcd_q[0]   <= 4'd0;
      bcd_q[1]   <= 4'd0;
      bcd_q[2]   <= 4'd0;
      bcd_q[3]   <= 4'd0;
      count_q    <= 3'd0;
      unlock_q   <= 1'b0;
      error_q    <= 1'b0;
      alarm_q    <= 1'b0;
      attempts_q <= 4'd0;
      timer_q    <= '0;
    end else begin
      // error_o is a single-cycle pulse; only the failed CHECK re-asserts it
      error_q <= 1'b0;
      case (state_q)
        ST_ENTRY: begin
          // clear has priority over a simultaneous digit strobe
          if (bus.clear_i) begin
            bcd_q[0] <= 4'd0;
            bcd_q[1] <= 4'd0;
            bcd_q[2] <= 4'd0;
            bcd_q[3] <= 4'd0;
            count_q  <= 3'd0;
          end else if (bus.digit_valid_i && (bus.digit_i <= 4'd9) && (count_q < 3'd4)) begin
            bcd_q[3] <= bcd_q[2];
            bcd_q[2] <= bcd_q[1];
            bcd_q[1] <= bcd_q[0];
            bcd_q[0] <= bus.digit_i;
            count_q  <= count_q + 3'd1;
            // fourth digit: comparator sees the full code in the very next cycle
            if (count_q == 3'd3) begin
              state_q <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          bcd_q[0] <= 4'd0;
          bcd_q[1] <= 4'd0;
          bcd_q[2] <= 4'd0;
          bcd_q[3] <= 4'd0;
          count_q  <= 3'd0;
          if (bus.equal_i) begin
            state_q    <= ST_OPEN;
            attempts_q <= 4'd0;
            timer_q    <= c_unlock_load;
            unlock_q   <= 1'b1;
          end else if (attempts_inc_d == c_max_attempts) begin
            state_q    <= ST_LOCKOUT;
            attempts_q <= attempts_inc_d;
            timer_q    <= c_lockout_load;
            alarm_q    <= 1'b1;
          end else begin
            state_q    <= ST_ENTRY;
            attempts_q <= attempts_inc_d;
            error_q    <= 1'b1;
          end
        end

        ST_OPEN: begin
          if (bus.clear_i || (timer_q == '0)) begin
            state_q  <= ST_ENTRY;
            unlock_q <= 1'b0;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        ST_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q    <= ST_ENTRY;
            alarm_q    <= 1'b0;
            attempts_q <= 4'd0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        default: begin
          state_q <= ST_ENTRY;
        end
      endcase
    end
  end

  assign bus.bcd_0_o       = bcd_q[0];
  assign bus.bcd_1_o       = bcd_q[1];
  assign bus.bcd_2_o       = bcd_q[2];
  assign bus.bcd_3_o       = bcd_q[3];
  assign bus.digit_count_o = count_q;
  assign bus.unlock_o      = unlock_q;
  assign bus.error_o       = error_q;
  assign bus.alarm_o       = alarm_q;
  // Decoded rather than registered so the comparator result is sampled in CHECK
  assign bus.cmp_enable_o  = (state_q == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_code_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_controller
// Purpose  : Self-checking bench for code_lock_controller. A transaction-level
//            model holds the entered digits in a queue and the failure count
//            as an integer, and derives the expected unlock / error / alarm
//            windows directly from the lock rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_code_lock_controller;

  localparam int MAXA = 3;
  localparam int UNL  = 4;
  localparam int LCK  = 6;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  code_lock_controller_if bus ();

  code_lock_controller #(
    .MAX_ATTEMPTS   (MAXA),
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LCK)
  ) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Comparator programmed with 2,8,0,1 on bcd_0..bcd_3
  assign bus.equal_i = bus.cmp_enable_o &&
                       (bus.bcd_0_o == 4'd2) && (bus.bcd_1_o == 4'd8) &&
                       (bus.bcd_2_o == 4'd0) && (bus.bcd_3_o == 4'd1);

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int held[$];       // held[0] is the newest digit
  int attempts = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int eb(input int i);
    return (i < held.size()) ? held[i] : 0;
  endfunction

  task automatic check_entry(input string tag);
    chk({tag, ".cnt"},  int'(bus.digit_count_o), held.size());
    chk({tag, ".bcd0"}, int'(bus.bcd_0_o), eb(0));
    chk({tag, ".bcd1"}, int'(bus.bcd_1_o), eb(1));
    chk({tag, ".bcd2"}, int'(bus.bcd_2_o), eb(2));
    chk({tag, ".bcd3"}, int'(bus.bcd_3_o), eb(3));
    chk({tag, ".cmp"},  int'(bus.cmp_enable_o), (held.size() == 4) ? 1 : 0);
    chk({tag, ".unl"},  int'(bus.unlock_o), 0);
    chk({tag, ".err"},  int'(bus.error_o), 0);
    chk({tag, ".alm"},  int'(bus.alarm_o), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    held.delete();
    attempts = 0;
    check_entry(tag);
  endtask

  task automatic enter_digit(input int d, input bit clr);
    bus.digit_valid_i = 1'b1;
    bus.digit_i       = 4'(d);
    bus.clear_i       = clr;
    tick();
    bus.digit_valid_i = 1'b0;
    bus.clear_i       = 1'b0;
    if (clr) held.delete();
    else if (d <= 9 && held.size() < 4) held.push_front(d);
    check_entry("digit");
  endtask

  task automatic clear_entry();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    held.delete();
    check_entry("clear");
  endtask

  // Enters a code (top nibble first) from an empty entry, then follows the
  // outcome. clear_at / rst_at name the 1-based OPEN/LOCKOUT cycle in which
  // clear_i or rst_i is applied (0 = never).
  task automatic enter_code(input logic [15:0] code, input int clear_at,
                            input int rst_at, input bit noise);
    bit match;
    for (int k = 0; k < 4; k++) begin
      if (noise) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          tick();
          check_entry("gap");
        end
        if ($urandom_range(0, 2) == 0) enter_digit($urandom_range(10, 15), 1'b0);
      end
      enter_digit(int'(code[15-4*k -: 4]), 1'b0);
    end
    // now in the CHECK cycle
    match = (held.size() == 4) && held[0] == 2 && held[1] == 8 && held[2] == 0 && held[3] == 1;
    held.delete();
    tick();
    chk("post.cmp", int'(bus.cmp_enable_o), 0);
    chk("post.cnt", int'(bus.digit_count_o), 0);
    if (match) begin
      attempts = 0;
      for (int i = 1; i <= UNL; i++) begin
        chk("open.unl", int'(bus.unlock_o), 1);
        chk("open.alm", int'(bus.alarm_o), 0);
        chk("open.err", int'(bus.error_o), 0);
        chk("open.cnt", int'(bus.digit_count_o), 0);
        if (rst_at == i) begin
          do_reset("rst_open");
          return;
        end
        bus.digit_valid_i = 1'($urandom_range(0, 1));
        bus.digit_i       = 4'($urandom_range(0, 15));
        bus.clear_i       = (clear_at == i);
        tick();
        bus.digit_valid_i = 1'b0;
        bus.clear_i       = 1'b0;
        if (clear_at == i) break;
      end
      check_entry("open_end");
    end else begin
      attempts++;
      if (attempts == MAXA) begin
        for (int i = 1; i <= LCK; i++) begin
          chk("lock.alm", int'(bus.alarm_o), 1);
          chk("lock.unl", int'(bus.unlock_o), 0);
          chk("lock.err", int'(bus.error_o), 0);
          chk("lock.cnt", int'(bus.digit_count_o), 0);
          if (rst_at == i) begin
            do_reset("rst_lock");
            return;
          end
          bus.digit_valid_i = 1'($urandom_range(0, 1));
          bus.digit_i       = 4'($urandom_range(0, 9));
          bus.clear_i       = 1'($urandom_range(0, 1));
          tick();
          bus.digit_valid_i = 1'b0;
          bus.clear_i       = 1'b0;
        end
        attempts = 0;
        check_entry("lock_end");
      end else begin
        chk("fail.err", int'(bus.error_o), 1);
        chk("fail.unl", int'(bus.unlock_o), 0);
        chk("fail.alm", int'(bus.alarm_o), 0);
        tick();
        check_entry("fail_end");
      end
    end
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    for (int k = 0; k < 4; k++) c[4*k +: 4] = 4'($urandom_range(0, 9));
    return c;
  endfunction

  initial begin
    bus.digit_valid_i = 1'b0;
    bus.digit_i       = 4'd0;
    bus.clear_i       = 1'b0;
    rst_i             = 1'b1;
    tick();
    do_reset("reset");

    // correct code, then wrong, then correct
    enter_code(16'h1082, 0, 0, 1'b0);
    enter_code(16'h1083, 0, 0, 1'b0);
    enter_code(16'h1082, 0, 0, 1'b0);

    // three wrong codes -> two errors then lockout; correct code afterwards
    enter_code(16'h1083, 0, 0, 1'b0);
    enter_code(16'h5555, 0, 0, 1'b1);
    enter_code(16'h9999, 0, 0, 1'b0);
    enter_code(16'h1082, 0, 0, 1'b0);

    // partial entry with clear, invalid digit ignored
    enter_digit(1, 1'b0);
    enter_digit(0, 1'b0);
    clear_entry();
    enter_digit(8, 1'b0);
    enter_digit(12, 1'b0);
    enter_digit(2, 1'b0);
    enter_digit(5, 1'b1);        // clear wins over a simultaneous digit
    tick();
    check_entry("idle");

    // early relock in the 2nd OPEN cycle
    enter_code(16'h1082, 2, 0, 1'b0);

    // reset during OPEN, then during LOCKOUT; attempts restart afterwards
    enter_code(16'h1082, 0, 2, 1'b0);
    enter_code(16'h4321, 0, 0, 1'b0);
    enter_code(16'h4321, 0, 0, 1'b0);
    enter_code(16'h4321, 0, 3, 1'b0);
    enter_code(16'h7777, 0, 0, 1'b0);
    enter_code(16'h7777, 0, 0, 1'b0);
    enter_code(16'h1082, 0, 0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int sel = $urandom_range(0, 4);
      if (sel == 0) begin
        enter_code(16'h1082, $urandom_range(0, UNL), ($urandom_range(0, 7) == 0) ? $urandom_range(1, UNL) : 0, 1'b1);
      end else if (sel <= 2) begin
        enter_code(rand_code(), 0, ($urandom_range(0, 7) == 0) ? $urandom_range(1, LCK) : 0, 1'b1);
      end else begin
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) enter_digit($urandom_range(0, 15), 1'b0);
        if ($urandom_range(0, 1) == 1) enter_digit($urandom_range(0, 9), 1'b1);
        else clear_entry();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // absolute bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
